fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit_npc_mux.sv | 48 ++++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants: reset/exception vectors, instruction-memory window,
// next-PC source encodings and exception codes.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP_DEF   = 32'h0000_6FFC;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    typedef enum logic [4:0] {
        EXC_NONE = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_RI   = 5'd10
    } excode_e;

    // Misaligned or outside the instruction window; unsigned compares.
    function automatic logic fetch_addr_err(input logic [31:0] pc,
                                            input logic [31:0] base,
                                            input logic [31:0] top);
        return (pc[1:0] != 2'b00) || (pc < base) || (pc > top);
    endfunction

endpackage

// File: rtl/fetch_unit_npc_mux.sv
// Next-PC selection: purely combinational, fixed priority
// reset > exception > eret > stall > npc_sel source.
module npc_mux
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        reset,
    input  logic        en,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] pc,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] epc,
    output logic [31:0] npc
);

    logic [31:0] pc_plus4;
    logic [31:0] seq_npc;

    assign pc_plus4 = pc + 32'd4;

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        seq_npc = pc_plus4;
        case (npc_sel_e'(npc_sel))
            NPC_PC4: seq_npc = pc_plus4;
            NPC_BR:  seq_npc = br_target;
            NPC_J:   seq_npc = j_target;
            NPC_JR:  seq_npc = jr_target;
            default: seq_npc = pc_plus4;
        endcase
    end

    always_comb begin
        npc = seq_npc;
        if (reset)         npc = RESET_PC;
        else if (exc_req)  npc = EXC_VEC;
        else if (eret_req) npc = epc;
        else if (!en)      npc = pc;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC and branch-delay-slot registers, zero-latency
// fetch with address-error detection (AdEL) that never stalls the PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter logic [31:0] IM_TOP   = IM_TOP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    input  logic        is_jump_D,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic [31:0] instr_in,
    output logic [31:0] im_addr,
    output logic [31:0] instr_F,
    output logic [31:0] pc_F,
    output logic [4:0]  excode_F,
    output logic        bd_F
);

    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic        addr_err;

    npc_mux #(
        .RESET_PC (RESET_PC),
        .EXC_VEC  (EXC_VEC)
    ) u_npc_mux (
        .reset     (reset),
        .en        (en),
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .npc_sel   (npc_sel),
        .pc        (pc_q),
        .br_target (br_target),
        .j_target  (j_target),
        .jr_target (jr_target),
        .epc       (epc),
        .npc       (pc_d)
    );

    // Redirects flush the delay-slot flag ahead of any load from decode.
    always_comb begin
        bd_d = bd_q;
        if (reset)                    bd_d = 1'b0;
        else if (exc_req || eret_req) bd_d = 1'b0;
        else if (en)                  bd_d = is_jump_D;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
        bd_q <= bd_d;
    end

    assign addr_err = fetch_addr_err(pc_q, IM_BASE, IM_TOP);

    assign im_addr  = pc_q;
    assign pc_F     = pc_q;
    assign bd_F     = bd_q;
    assign excode_F = addr_err ? EXC_ADEL : EXC_NONE;
    assign instr_F  = addr_err ? 32'h0 : instr_in;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the expected post-edge
// state, a negedge monitor pops and compares against the DUT outputs.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  npc_sel;
    logic [31:0] br_target, j_target, jr_target;
    logic        is_jump_D;
    logic        exc_req, eret_req;
    logic [31:0] epc;
    logic [31:0] instr_in;
    logic [31:0] im_addr, instr_F, pc_F;
    logic [4:0]  excode_F;
    logic        bd_F;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        bd;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .npc_sel   (npc_sel),
        .br_target (br_target),
        .j_target  (j_target),
        .jr_target (jr_target),
        .is_jump_D (is_jump_D),
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .epc       (epc),
        .instr_in  (instr_in),
        .im_addr   (im_addr),
        .instr_F   (instr_F),
        .pc_F      (pc_F),
        .excode_F  (excode_F),
        .bd_F      (bd_F)
    );

    // Instruction memory model: read data is a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign instr_in = mem_word(im_addr);

    function automatic logic exp_adel(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
    endfunction

    task automatic check(input exp_t e);
        logic [4:0]  x_exc;
        logic [31:0] x_instr;
        x_exc   = exp_adel(e.pc) ? 5'd4 : 5'd0;
        x_instr = exp_adel(e.pc) ? 32'h0 : mem_word(e.pc);
        vectors++;
        if (pc_F !== e.pc || im_addr !== e.pc || bd_F !== e.bd ||
            excode_F !== x_exc || instr_F !== x_instr) begin
            miscompares++;
            $display("FAIL %s: got pc_F=%h im_addr=%h bd_F=%b excode_F=%0d instr_F=%h, want pc=%h bd=%b excode=%0d instr=%h",
                     e.name, pc_F, im_addr, bd_F, excode_F, instr_F,
                     e.pc, e.bd, x_exc, x_instr);
        end
    endtask

    // Monitor: compares every pending expectation away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) check(exp_q.pop_front());
    end

    task automatic tick(input string name, input logic [31:0] pc, input logic bd);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = name;
        e.pc   = pc;
        e.bd   = bd;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; npc_sel = 2'd0;
        br_target = '0; j_target = '0; jr_target = '0;
        is_jump_D = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;

        // Reset two cycles, then sequential fetch.
        tick("reset_0", 32'h3000, 1'b0);
        tick("reset_1", 32'h3000, 1'b0);
        reset = 1'b0; en = 1'b1;
        tick("seq_3004", 32'h3004, 1'b0);
        tick("seq_3008", 32'h3008, 1'b0);
        tick("seq_300c", 32'h300C, 1'b0);
        tick("seq_3010", 32'h3010, 1'b0);

        // Taken branch with delay slot flag.
        npc_sel = 2'd1; br_target = 32'h3040; is_jump_D = 1'b1;
        tick("br_taken", 32'h3040, 1'b1);
        npc_sel = 2'd0; is_jump_D = 1'b0;
        tick("br_after", 32'h3044, 1'b0);

        // Jump to 3020 with bd set, then stall three cycles holding both.
        npc_sel = 2'd2; j_target = 32'h3020; is_jump_D = 1'b1;
        tick("j_3020", 32'h3020, 1'b1);
        en = 1'b0; npc_sel = 2'd1; is_jump_D = 1'b0;
        tick("stall_0", 32'h3020, 1'b1);
        tick("stall_1", 32'h3020, 1'b1);
        tick("stall_2", 32'h3020, 1'b1);
        exc_req = 1'b1;
        tick("exc_stalled", 32'h4180, 1'b0);
        exc_req = 1'b0;

        // Fetch address error boundaries.
        en = 1'b1; npc_sel = 2'd3;
        jr_target = 32'h3002;
        tick("jr_misalign", 32'h3002, 1'b0);
        jr_target = 32'h7000;
        tick("jr_above_top", 32'h7000, 1'b0);
        jr_target = 32'h6FFC;
        tick("jr_at_top", 32'h6FFC, 1'b0);
        jr_target = 32'h2FFC;
        tick("jr_below_base", 32'h2FFC, 1'b0);
        jr_target = 32'hFFFF_FFFC;
        tick("jr_max", 32'hFFFF_FFFC, 1'b0);
        npc_sel = 2'd0;
        tick("pc4_wrap", 32'h0000_0000, 1'b0);

        // Exception beats eret; then eret alone, then bd loads again.
        is_jump_D = 1'b1; exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3100;
        tick("exc_over_eret", 32'h4180, 1'b0);
        exc_req = 1'b0; en = 1'b0;
        tick("eret", 32'h3100, 1'b0);
        eret_req = 1'b0; en = 1'b1;
        tick("after_eret", 32'h3104, 1'b1);

        // Reset overrides a simultaneous exception and jump.
        reset = 1'b1; exc_req = 1'b1; npc_sel = 2'd2; j_target = 32'h5000;
        tick("reset_over_exc", 32'h3000, 1'b0);
        reset = 1'b0; exc_req = 1'b0; en = 1'b0;
        tick("post_reset_hold", 32'h3000, 1'b0);

        @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
